// File: rtl/ysyx_25020037_axi_arbiter_pkg.sv
// Shared constants for the IFU/LSU AXI arbiter: FSM state encodings, AXI burst/resp codes,
// and the round-robin history encoding.
package ysyx_25020037_axi_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_IFU_RD = 2'd1;
  localparam logic [1:0] ARB_LSU_RD = 2'd2;
  localparam logic [1:0] ARB_LSU_WR = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  // rr_last value naming the most recent read winner
  localparam logic RR_IFU = 1'b0;
  localparam logic RR_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25020037_axi_arbiter_arb_pick.sv
// Two-requester picker: req[0]=IFU, req[1]=LSU. Fixed LSU priority, or round-robin
// against rr_last when en_rr is set.
module ysyx_25020037_arb_pick
  import ysyx_25020037_axi_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       en_rr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (en_rr && rr_last == RR_LSU) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Shares one AXI4 master port between IFU (reads) and LSU (reads/writes), one whole
// transaction at a time. Define YSYX_25020037_ARB_RR_EN for round-robin read arbitration.
module ysyx_25020037_axi_arbiter
  import ysyx_25020037_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  // IFU
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [ID_W-1:0]     ifu_arid,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic [1:0]          ifu_arburst,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rlast,
  output logic [ID_W-1:0]     ifu_rid,
  // LSU
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [ID_W-1:0]     lsu_arid,
  input  logic [2:0]          lsu_arsize,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rlast,
  output logic [ID_W-1:0]     lsu_rid,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [ID_W-1:0]     lsu_awid,
  input  logic [2:0]          lsu_awsize,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,
  output logic [ID_W-1:0]     lsu_bid,
  // bus
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [ID_W-1:0]     m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic [ID_W-1:0]     m_rid,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [ID_W-1:0]     m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  input  logic [ID_W-1:0]     m_bid
);

`ifdef YSYX_25020037_ARB_RR_EN
  localparam logic EN_RR = 1'b1;
`else
  localparam logic EN_RR = 1'b0;
`endif

  logic [1:0] state, state_nxt;
  logic       rr_last;
  logic [1:0] gnt;

  ysyx_25020037_arb_pick u_pick (
    .req     ({lsu_arvalid, ifu_arvalid}),
    .rr_last (rr_last),
    .en_rr   (EN_RR),
    .gnt     (gnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (lsu_awvalid)  state_nxt = ARB_LSU_WR;
        else if (gnt[1])  state_nxt = ARB_LSU_RD;
        else if (gnt[0])  state_nxt = ARB_IFU_RD;
      end
      ARB_IFU_RD, ARB_LSU_RD:
        if (m_rvalid && m_rready && m_rlast) state_nxt = ARB_IDLE;
      ARB_LSU_WR:
        if (m_bvalid && m_bready) state_nxt = ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      rr_last <= RR_IFU;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && !lsu_awvalid && gnt != 2'b00)
        rr_last <= gnt[1] ? RR_LSU : RR_IFU;
    end
  end

  // Every output defaults to 0 so IDLE and the losing master see a quiet interface.
  always_comb begin
    ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = '0; ifu_rresp = '0;
    ifu_rlast   = 1'b0; ifu_rid    = '0;
    lsu_arready = 1'b0; lsu_rvalid = 1'b0; lsu_rdata = '0; lsu_rresp = '0;
    lsu_rlast   = 1'b0; lsu_rid    = '0;
    lsu_awready = 1'b0; lsu_wready = 1'b0; lsu_bvalid = 1'b0; lsu_bresp = '0; lsu_bid = '0;
    m_arvalid = 1'b0; m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid  = 1'b0; m_wdata  = '0; m_wstrb = '0; m_wlast = 1'b0;
    m_bready  = 1'b0;
    case (state)
      ARB_IFU_RD: begin
        m_arvalid = ifu_arvalid; m_araddr = ifu_araddr; m_arid = ifu_arid;
        m_arlen = ifu_arlen; m_arsize = ifu_arsize; m_arburst = ifu_arburst;
        ifu_arready = m_arready;
        ifu_rvalid = m_rvalid; ifu_rdata = m_rdata; ifu_rresp = m_rresp;
        ifu_rlast = m_rlast; ifu_rid = m_rid;
        m_rready = ifu_rready;
      end
      ARB_LSU_RD: begin
        m_arvalid = lsu_arvalid; m_araddr = lsu_araddr; m_arid = lsu_arid;
        m_arlen = 8'd0; m_arsize = lsu_arsize; m_arburst = BURST_FIXED;
        lsu_arready = m_arready;
        lsu_rvalid = m_rvalid; lsu_rdata = m_rdata; lsu_rresp = m_rresp;
        lsu_rlast = m_rlast; lsu_rid = m_rid;
        m_rready = lsu_rready;
      end
      ARB_LSU_WR: begin
        m_awvalid = lsu_awvalid; m_awaddr = lsu_awaddr; m_awid = lsu_awid;
        m_awlen = 8'd0; m_awsize = lsu_awsize; m_awburst = BURST_FIXED;
        lsu_awready = m_awready;
        m_wvalid = lsu_wvalid; m_wdata = lsu_wdata; m_wstrb = lsu_wstrb; m_wlast = 1'b1;
        lsu_wready = m_wready;
        lsu_bvalid = m_bvalid; lsu_bresp = m_bresp; lsu_bid = m_bid;
        m_bready = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed self-checking bench for ysyx_25020037_axi_arbiter; the bench acts as IFU, LSU
// and bus slave, with expected values written by hand per scenario.
module tb_ysyx_25020037_axi_arbiter;
  import ysyx_25020037_axi_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_araddr;
  logic [3:0]  ifu_arid;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst;
  logic        ifu_rvalid, ifu_rready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rlast;
  logic [3:0]  ifu_rid;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_araddr;
  logic [3:0]  lsu_arid;
  logic [2:0]  lsu_arsize;
  logic        lsu_rvalid, lsu_rready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rlast;
  logic [3:0]  lsu_rid;
  logic        lsu_awvalid, lsu_awready;
  logic [31:0] lsu_awaddr;
  logic [3:0]  lsu_awid;
  logic [2:0]  lsu_awsize;
  logic        lsu_wvalid, lsu_wready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_bvalid, lsu_bready;
  logic [1:0]  lsu_bresp;
  logic [3:0]  lsu_bid;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [3:0]  m_rid;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic [3:0]  m_bid;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_25020037_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arid(lsu_arid), .lsu_arsize(lsu_arsize),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
    .lsu_awid(lsu_awid), .lsu_awsize(lsu_awsize),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_arvalid = 0; ifu_araddr = '0; ifu_arid = '0; ifu_arlen = '0; ifu_arsize = '0;
    ifu_arburst = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arid = '0; lsu_arsize = '0; lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = '0; lsu_awid = '0; lsu_awsize = '0;
    lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_bready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rid = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0; m_bid = '0;
  endtask

  // One single-beat R response on the bus, then back to IDLE.
  task automatic bus_beat(input logic [31:0] data);
    m_rvalid = 1; m_rdata = data; m_rlast = 1;
    tick();
    m_rvalid = 0; m_rlast = 0; m_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    ifu_arvalid = 1; m_arready = 1; m_rvalid = 1;
    tick(); tick();
    n_cmp++; if (ifu_arready !== 1'b0) begin n_bad++; $display("FAIL rst_ifu_arready: got %b want 0", ifu_arready); end
    n_cmp++; if (m_arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_m_arvalid: got %b want 0", m_arvalid); end
    n_cmp++; if (ifu_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_ifu_rvalid: got %b want 0", ifu_rvalid); end
    n_cmp++; if (m_rready !== 1'b0) begin n_bad++; $display("FAIL rst_m_rready: got %b want 0", m_rready); end
    clear_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_ifu_burst();
    m_arready = 1; ifu_rready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'hA000_0000; ifu_arid = 4'h5; ifu_arlen = 8'd3;
    ifu_arsize = 3'd2; ifu_arburst = BURST_INCR;
    #1;
    n_cmp++; if (m_arvalid !== 1'b0) begin n_bad++; $display("FAIL burst_idle_arvalid: got %b want 0", m_arvalid); end
    tick();
    n_cmp++; if (m_arvalid !== 1'b1) begin n_bad++; $display("FAIL burst_m_arvalid: got %b want 1", m_arvalid); end
    n_cmp++; if (m_araddr !== 32'hA000_0000) begin n_bad++; $display("FAIL burst_m_araddr: got %h want a0000000", m_araddr); end
    n_cmp++; if (m_arlen !== 8'd3) begin n_bad++; $display("FAIL burst_m_arlen: got %0d want 3", m_arlen); end
    n_cmp++; if (m_arburst !== BURST_INCR) begin n_bad++; $display("FAIL burst_m_arburst: got %b want 01", m_arburst); end
    n_cmp++; if (ifu_arready !== 1'b1) begin n_bad++; $display("FAIL burst_ifu_arready: got %b want 1", ifu_arready); end
    tick();
    ifu_arvalid = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      m_rvalid = 1; m_rdata = 32'h1000 + i; m_rlast = (i == 3); m_rid = 4'h5;
      #1;
      n_cmp++; if (ifu_rvalid !== 1'b1) begin n_bad++; $display("FAIL burst_rvalid_%0d: got %b want 1", i, ifu_rvalid); end
      n_cmp++; if (ifu_rdata !== 32'h1000 + i) begin n_bad++; $display("FAIL burst_rdata_%0d: got %h want %h", i, ifu_rdata, 32'h1000 + i); end
      n_cmp++; if (ifu_rlast !== (i == 3)) begin n_bad++; $display("FAIL burst_rlast_%0d: got %b want %b", i, ifu_rlast, (i == 3)); end
      tick();
    end
    // bus still shows rvalid; IDLE must hide it
    #1;
    n_cmp++; if (ifu_rvalid !== 1'b0) begin n_bad++; $display("FAIL burst_after_rvalid: got %b want 0", ifu_rvalid); end
    n_cmp++; if (m_rready !== 1'b0) begin n_bad++; $display("FAIL burst_after_rready: got %b want 0", m_rready); end
    clear_inputs();
    tick();
  endtask

  task automatic test_conflict();
    m_arready = 1; ifu_rready = 1; lsu_rready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0100; ifu_arlen = 8'd0; ifu_arburst = BURST_INCR;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_2000; lsu_arsize = 3'd2;
    tick();
    n_cmp++; if (lsu_arready !== 1'b1) begin n_bad++; $display("FAIL conf_lsu_arready: got %b want 1", lsu_arready); end
    n_cmp++; if (ifu_arready !== 1'b0) begin n_bad++; $display("FAIL conf_ifu_arready: got %b want 0", ifu_arready); end
    n_cmp++; if (m_araddr !== 32'h8000_2000) begin n_bad++; $display("FAIL conf_m_araddr: got %h want 80002000", m_araddr); end
    n_cmp++; if (m_arburst !== BURST_FIXED) begin n_bad++; $display("FAIL conf_m_arburst: got %b want 00", m_arburst); end
    tick();
    lsu_arvalid = 0;
    m_rvalid = 1; m_rdata = 32'hCAFE_0001; m_rlast = 1;
    #1;
    n_cmp++; if (lsu_rdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL conf_lsu_rdata: got %h want cafe0001", lsu_rdata); end
    n_cmp++; if (ifu_rvalid !== 1'b0) begin n_bad++; $display("FAIL conf_ifu_rvalid: got %b want 0", ifu_rvalid); end
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    n_cmp++; if (ifu_arready !== 1'b0) begin n_bad++; $display("FAIL conf_gap_ifu_arready: got %b want 0", ifu_arready); end
    tick();
    n_cmp++; if (ifu_arready !== 1'b1) begin n_bad++; $display("FAIL conf_ifu_late_arready: got %b want 1", ifu_arready); end
    n_cmp++; if (m_araddr !== 32'h8000_0100) begin n_bad++; $display("FAIL conf_ifu_m_araddr: got %h want 80000100", m_araddr); end
    tick();
    ifu_arvalid = 0;
    bus_beat(32'h0);
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_lsu;
`ifdef YSYX_25020037_ARB_RR_EN
    exp_lsu = 4'b0101;
`else
    exp_lsu = 4'b1111;
`endif
    m_arready = 1; ifu_rready = 1; lsu_rready = 1;
    ifu_araddr = 32'h100; lsu_araddr = 32'h200;
    for (int unsigned r = 0; r < 4; r++) begin
      ifu_arvalid = 1; lsu_arvalid = 1;
      tick();
      n_cmp++; if (lsu_arready !== exp_lsu[r]) begin n_bad++; $display("FAIL rr_round_%0d: got lsu_arready %b want %b", r, lsu_arready, exp_lsu[r]); end
      tick();
      if (exp_lsu[r]) lsu_arvalid = 0; else ifu_arvalid = 0;
      bus_beat(32'h0);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_priority();
    m_arready = 1; ifu_rready = 1; lsu_bready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'h3000;
    lsu_awvalid = 1; lsu_awaddr = 32'h4000_0010; lsu_awid = 4'h3; lsu_awsize = 3'd2;
    lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    m_wready = 1; m_awready = 0;
    tick();
    n_cmp++; if (lsu_wready !== 1'b1) begin n_bad++; $display("FAIL wr_lsu_wready: got %b want 1", lsu_wready); end
    n_cmp++; if (lsu_awready !== 1'b0) begin n_bad++; $display("FAIL wr_lsu_awready_early: got %b want 0", lsu_awready); end
    n_cmp++; if (m_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_m_wdata: got %h want deadbeef", m_wdata); end
    n_cmp++; if (m_wlast !== 1'b1) begin n_bad++; $display("FAIL wr_m_wlast: got %b want 1", m_wlast); end
    n_cmp++; if (ifu_arready !== 1'b0) begin n_bad++; $display("FAIL wr_ifu_arready: got %b want 0", ifu_arready); end
    tick();
    lsu_wvalid = 0; m_awready = 1;
    #1;
    n_cmp++; if (lsu_awready !== 1'b1) begin n_bad++; $display("FAIL wr_lsu_awready: got %b want 1", lsu_awready); end
    n_cmp++; if (m_awaddr !== 32'h4000_0010) begin n_bad++; $display("FAIL wr_m_awaddr: got %h want 40000010", m_awaddr); end
    n_cmp++; if (m_awlen !== 8'd0) begin n_bad++; $display("FAIL wr_m_awlen: got %0d want 0", m_awlen); end
    tick();
    lsu_awvalid = 0; m_awready = 0;
    m_bvalid = 1; m_bresp = RESP_OKAY; m_bid = 4'h3;
    #1;
    n_cmp++; if (lsu_bvalid !== 1'b1) begin n_bad++; $display("FAIL wr_lsu_bvalid: got %b want 1", lsu_bvalid); end
    n_cmp++; if (lsu_bresp !== 2'b00) begin n_bad++; $display("FAIL wr_lsu_bresp: got %b want 00", lsu_bresp); end
    n_cmp++; if (lsu_bid !== 4'h3) begin n_bad++; $display("FAIL wr_lsu_bid: got %h want 3", lsu_bid); end
    tick();
    m_bvalid = 0;
    tick();
    n_cmp++; if (ifu_arready !== 1'b1) begin n_bad++; $display("FAIL wr_then_ifu_arready: got %b want 1", ifu_arready); end
    n_cmp++; if (m_araddr !== 32'h3000) begin n_bad++; $display("FAIL wr_then_m_araddr: got %h want 3000", m_araddr); end
    tick();
    ifu_arvalid = 0;
    bus_beat(32'h0);
    clear_inputs();
    tick();
  endtask

  task automatic test_no_preempt();
    m_arready = 1; ifu_rready = 1; lsu_rready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'hA000_0040; ifu_arlen = 8'd3; ifu_arburst = BURST_INCR;
    tick();
    tick();
    ifu_arvalid = 0;
    lsu_arvalid = 1; lsu_araddr = 32'h5000;
    for (int unsigned i = 0; i < 4; i++) begin
      m_rvalid = 1; m_rdata = 32'h2000 + i; m_rlast = (i == 3);
      #1;
      n_cmp++; if (lsu_arready !== 1'b0) begin n_bad++; $display("FAIL nopre_lsu_arready_%0d: got %b want 0", i, lsu_arready); end
      tick();
    end
    m_rvalid = 0; m_rlast = 0;
    #1;
    n_cmp++; if (lsu_arready !== 1'b0) begin n_bad++; $display("FAIL nopre_gap_lsu_arready: got %b want 0", lsu_arready); end
    tick();
    n_cmp++; if (lsu_arready !== 1'b1) begin n_bad++; $display("FAIL nopre_lsu_granted: got %b want 1", lsu_arready); end
    tick();
    lsu_arvalid = 0;
    bus_beat(32'h0);
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    m_arready = 1; ifu_rready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'hA000_0080; ifu_arlen = 8'd3; ifu_arburst = BURST_INCR;
    tick();
    tick();
    ifu_arvalid = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      m_rvalid = 1; m_rdata = 32'h3000 + i; m_rlast = 0;
      tick();
    end
    m_rdata = 32'h3002;
    #1;
    n_cmp++; if (ifu_rvalid !== 1'b1) begin n_bad++; $display("FAIL rmid_beat2_rvalid: got %b want 1", ifu_rvalid); end
    rst = 1;
    #1;
    n_cmp++; if (ifu_rvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_ifu_rvalid: got %b want 0", ifu_rvalid); end
    n_cmp++; if (m_rready !== 1'b0) begin n_bad++; $display("FAIL rmid_m_rready: got %b want 0", m_rready); end
    n_cmp++; if (ifu_arready !== 1'b0) begin n_bad++; $display("FAIL rmid_ifu_arready: got %b want 0", ifu_arready); end
    tick();
    clear_inputs();
    rst = 0;
    tick();
    m_arready = 1; ifu_rready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'hA000_00C0; ifu_arlen = 8'd0; ifu_arburst = BURST_INCR;
    tick();
    n_cmp++; if (ifu_arready !== 1'b1) begin n_bad++; $display("FAIL rmid_fresh_arready: got %b want 1", ifu_arready); end
    n_cmp++; if (m_araddr !== 32'hA000_00C0) begin n_bad++; $display("FAIL rmid_fresh_araddr: got %h want a00000c0", m_araddr); end
    tick();
    ifu_arvalid = 0;
    m_rvalid = 1; m_rdata = 32'h1234_5678; m_rlast = 1;
    #1;
    n_cmp++; if (ifu_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rmid_fresh_rdata: got %h want 12345678", ifu_rdata); end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_ifu_burst();
    test_conflict();
    test_round_robin();
    test_write_priority();
    test_no_preempt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
